// File: rtl/rvx_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package rvx_mem_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 1024;
    localparam int LATENCY_DEFAULT     = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_t;

    // True when a 30-bit word index addresses a real word of the array.
    function automatic logic idxInRange(input logic [29:0] idx, input int depth);
        return ({2'b00, idx} < 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-organised data memory with byte-lane writes and a registered read.
module dmem_array
    import rvx_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // One access per enabled cycle: a write touches only the enabled byte
    // lanes, a read updates the output register and writes leave it alone.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: captures one request, waits a fixed
// latency, performs the access on dmem_array and pulses a response.
module dmem_responder
    import rvx_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int LATENCY     = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqM,
    input  logic        WeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteEnM,
    output logic [31:0] ReadDataM,
    output logic        RespValidM,
    output logic        StallM,
    output logic        ErrM
);

    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    memState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             capture;
    logic             execute;

    logic             captWe;
    logic [29:0]      captIdx;
    logic [31:0]      captWdata;
    logic [3:0]       captBe;

    logic             inRange;
    logic             arrEn;
    logic [31:0]      arrRdata;
    logic [31:0]      loadData;
    logic [31:0]      lastLoad;
    logic             respLoad;
    logic             unusedAddrBits;

    // Byte offset bits never take part in word selection.
    assign unusedAddrBits = ^AddrM[1:0];

    assign inRange  = idxInRange(captIdx, DEPTH_WORDS);
    // Reset gating keeps an access scheduled for the reset edge out of memory.
    assign arrEn    = execute & inRange & ~reset;
    assign loadData = inRange ? arrRdata : 32'd0;
    assign respLoad = (state == RESP) & ~captWe;

    // State and latency counter register; reset wins over any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        execute   = 1'b0;
        case (state)
            IDLE: begin
                if (ReqM) begin
                    capture   = 1'b1;
                    cntNext   = CNT_LOAD;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    execute   = 1'b1;
                    stateNext = RESP;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance so the pipeline may drop ReqM later.
    always_ff @(posedge clk) begin
        if (reset) begin
            captWe    <= 1'b0;
            captIdx   <= '0;
            captWdata <= '0;
            captBe    <= '0;
        end else if (capture) begin
            captWe    <= WeM;
            captIdx   <= AddrM[31:2];
            captWdata <= WriteDataM;
            captBe    <= ByteEnM;
        end
    end

    // Remember the last completed load so ReadDataM holds between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastLoad <= '0;
        end else if (respLoad) begin
            lastLoad <= loadData;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (arrEn),
        .we   (captWe),
        .addr (captIdx[AW-1:0]),
        .wdata(captWdata),
        .be   (captBe),
        .rdata(arrRdata)
    );

    assign ReadDataM  = respLoad ? loadData : lastLoad;
    assign RespValidM = (state == RESP);
    assign ErrM       = RespValidM & ~inRange;
    assign StallM     = ReqM & ~RespValidM;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance driven through a
// queue of expected responses, plus LATENCY=1 and LATENCY=4 instances.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Count rising edges so responses can be checked against exact cycles.
    always @(posedge clk) cyc <= cyc + 1;

    logic        reqM, weM, rvalidM, stallM, errM;
    logic [31:0] addrM, wdataM, rdataM;
    logic [3:0]  beM;

    logic        req1, we1, rv1, stall1, err1;
    logic [31:0] addr1, wdata1, rd1;
    logic [3:0]  be1;

    logic        req4, we4, rv4, stall4, err4;
    logic [31:0] addr4, wdata4, rd4;
    logic [3:0]  be4;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .ReqM(reqM), .WeM(weM), .AddrM(addrM),
        .WriteDataM(wdataM), .ByteEnM(beM), .ReadDataM(rdataM),
        .RespValidM(rvalidM), .StallM(stallM), .ErrM(errM)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dutL1 (
        .clk(clk), .reset(reset), .ReqM(req1), .WeM(we1), .AddrM(addr1),
        .WriteDataM(wdata1), .ByteEnM(be1), .ReadDataM(rd1),
        .RespValidM(rv1), .StallM(stall1), .ErrM(err1)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(4)) dutL4 (
        .clk(clk), .reset(reset), .ReqM(req4), .WeM(we4), .AddrM(addr4),
        .WriteDataM(wdata4), .ByteEnM(be4), .ReadDataM(rd4),
        .RespValidM(rv4), .StallM(stall4), .ErrM(err4)
    );

    typedef struct {
        int          tag;
        logic [31:0] data;
        logic        err;
        int          respCyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every response pulse of the main instance is matched against
    // the oldest queued expectation (cycle, data, error flag).
    always @(negedge clk) begin
        if (rvalidM === 1'b1) begin
            pulses++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", {31'd0, rvalidM}, 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput($sformatf("resp%0d_cycle", monE.tag), cyc, monE.respCyc);
                checkOutput($sformatf("resp%0d_data", monE.tag), rdataM, monE.data);
                checkOutput($sformatf("resp%0d_err", monE.tag), {31'd0, errM}, {31'd0, monE.err});
            end
        end else if (errM !== 1'b0) begin
            checkOutput("err_without_valid", {31'd0, errM}, 32'd0);
        end
    end

    // Issue one access to the main instance from an idle DUT and wait for it.
    task automatic applyStimulus(input int tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] expData, input logic expErr);
        exp_t e;
        logic got;
        @(negedge clk);
        reqM = 1'b1; weM = we; addrM = addr; wdataM = wdata; beM = be;
        e.tag = tag; e.data = expData; e.err = expErr; e.respCyc = cyc + LAT + 1;
        expQ.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rvalidM === 1'b1) got = 1'b1;
        end
        reqM = 1'b0; weM = 1'b0;
        checkOutput($sformatf("resp%0d_seen", tag), {31'd0, got}, 32'd1);
        if (!got) expQ.delete();
    endtask

    // Access one of the small instances; optionally drop ReqM after dropAfter cycles.
    task automatic smallAccess(input logic useL4, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int dropAfter,
                               output int lat, output int npulse, output logic [31:0] data,
                               output logic errSeen);
        int   n;
        logic rv;
        @(negedge clk);
        if (useL4) begin
            req4 = 1'b1; we4 = we; addr4 = addr; wdata4 = wdata; be4 = be;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; be1 = be;
        end
        n = cyc; lat = -1; npulse = 0; data = 32'd0; errSeen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == dropAfter) begin
                req1 = 1'b0; req4 = 1'b0;
            end
            rv = useL4 ? rv4 : rv1;
            if (rv === 1'b1) begin
                npulse++;
                if (lat < 0) begin
                    lat = cyc - n;
                    data = useL4 ? rd4 : rd1;
                    errSeen = useL4 ? err4 : err1;
                end
                req1 = 1'b0; req4 = 1'b0;
            end
        end
        req1 = 1'b0; req4 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        int          k;
        int          p0;
        int          rel;
        logic        expStall;
        int          lat;
        int          np;
        logic [31:0] d;
        logic        e;

        reset = 1'b1;
        reqM = 1'b1; weM = 1'b0; addrM = 32'h10; wdataM = 32'd0; beM = 4'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0; be1 = 4'h0;
        req4 = 1'b0; we4 = 1'b0; addr4 = 32'd0; wdata4 = 32'd0; be4 = 4'h0;

        // Reset held with a request present: reset must win.
        repeat (3) @(negedge clk);
        checkOutput("reset_rvalid", {31'd0, rvalidM}, 32'd0);
        checkOutput("reset_err", {31'd0, errM}, 32'd0);
        checkOutput("reset_rdata", rdataM, 32'd0);
        checkOutput("reset_stall_with_req", {31'd0, stallM}, 32'd1);
        reset = 1'b0; reqM = 1'b0;
        @(negedge clk);
        checkOutput("idle_stall", {31'd0, stallM}, 32'd0);
        checkOutput("idle_rdata", rdataM, 32'd0);

        // Directed accesses on the LATENCY=2 instance.
        applyStimulus(1,  1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0);
        applyStimulus(2,  1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(3,  1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(4,  1'b1, 32'h0000_0020, 32'h0000_AA00, 4'h2, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(5,  1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_AA44, 1'b0);
        applyStimulus(6,  1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'hF, 32'h1122_AA44, 1'b0);
        applyStimulus(7,  1'b1, 32'h0000_0024, 32'h1234_5678, 4'h0, 32'h1122_AA44, 1'b0);
        applyStimulus(8,  1'b0, 32'h0000_0027, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0);
        applyStimulus(9,  1'b1, 32'h0000_0024, 32'hFF00_00EE, 4'h9, 32'hA5A5_A5A5, 1'b0);
        applyStimulus(10, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hFFA5_A5EE, 1'b0);
        applyStimulus(11, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'hFFA5_A5EE, 1'b0);
        applyStimulus(12, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0000_0000, 1'b1);
        applyStimulus(13, 1'b1, 32'h0000_1000, 32'hBADB_AD00, 4'hF, 32'h0000_0000, 1'b1);
        applyStimulus(14, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'hF, 32'h0000_0000, 1'b1);
        applyStimulus(15, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b0);
        applyStimulus(16, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(17, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(18, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0);

        // Three loads with ReqM held high; the address advances when the stall drops.
        @(negedge clk);
        n = cyc;
        p0 = pulses;
        for (int j = 0; j < 3; j++) begin
            exp_t x;
            x.tag = 20 + j;
            x.err = 1'b0;
            x.respCyc = n + LAT + 1 + j * (LAT + 2);
            x.data = (j == 0) ? 32'hDEAD_BEEF : (j == 1) ? 32'h1122_AA44 : 32'hFFA5_A5EE;
            expQ.push_back(x);
        end
        reqM = 1'b1; weM = 1'b0; addrM = 32'h10; beM = 4'h0;
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            rel = cyc - n - (LAT + 1);
            expStall = !(rel >= 0 && (rel % (LAT + 2)) == 0);
            checkOutput($sformatf("b2b_stall_c%0d", cyc - n), {31'd0, stallM}, {31'd0, expStall});
            if (rvalidM === 1'b1) begin
                k++;
                addrM = (k == 1) ? 32'h20 : 32'h24;
            end
        end
        reqM = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("b2b_pulse_count", pulses - p0, 32'd3);
        checkOutput("b2b_queue_drained", expQ.size(), 32'd0);
        expQ.delete();

        // Store aborted by reset one cycle after acceptance.
        applyStimulus(30, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'hFFA5_A5EE, 1'b0);
        @(negedge clk);
        reqM = 1'b1; weM = 1'b1; addrM = 32'h40; wdataM = 32'hCAFE_F00D; beM = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; reqM = 1'b0; weM = 1'b0;
        checkOutput("abort_rdata_cleared", rdataM, 32'd0);
        checkOutput("abort_rvalid", {31'd0, rvalidM}, 32'd0);
        repeat (6) @(negedge clk);
        applyStimulus(31, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
        applyStimulus(32, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // LATENCY=1 instance.
        smallAccess(1'b0, 1'b1, 32'h4, 32'h0000_0077, 4'hF, 0, lat, np, d, e);
        checkOutput("l1_store_latency", lat, 32'd2);
        smallAccess(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 0, lat, np, d, e);
        checkOutput("l1_load_latency", lat, 32'd2);
        checkOutput("l1_load_pulses", np, 32'd1);
        checkOutput("l1_load_data", d, 32'h0000_0077);
        smallAccess(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 0, lat, np, d, e);
        checkOutput("l1_oor_data", d, 32'd0);
        checkOutput("l1_oor_err", {31'd0, e}, 32'd1);

        // LATENCY=4 instance with ReqM dropped in the middle of WAIT.
        smallAccess(1'b1, 1'b1, 32'h8, 32'h0000_1234, 4'hF, 0, lat, np, d, e);
        checkOutput("l4_store_latency", lat, 32'd5);
        smallAccess(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 2, lat, np, d, e);
        checkOutput("l4_drop_pulses", np, 32'd1);
        checkOutput("l4_drop_latency", lat, 32'd5);
        checkOutput("l4_drop_data", d, 32'h0000_1234);
        checkOutput("l4_drop_err", {31'd0, e}, 32'd0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
